// File: rtl/debounce_event_ctrl.sv
// Multi-channel push-button debouncer with hysteretic stable levels and a
// round-robin serializer that presents press/release events on a valid/ready port.
module debounce_event_ctrl #(
  parameter int unsigned CH       = 4,
  parameter int unsigned N        = 3,
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned CW       = $clog2(CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] raw_in,
  output logic [CH-1:0] stable,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [CW-1:0] evt_ch,
  output logic          evt_press,
  output logic          ovf
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pcnt;
  logic          tick;

  logic [N-1:0]  hist    [CH];
  logic [N-1:0]  hist_nx [CH];
  logic [CH-1:0] stable_nx;
  logic [CH-1:0] post;

  logic [CH-1:0] pend, pend_nx;
  logic [CH-1:0] ptype, ptype_nx;
  logic [CW-1:0] last;
  logic          slot_free;
  logic          gnt;
  logic [CW-1:0] gnt_ch;
  logic          ovf_set;

  assign tick      = (pcnt == PW'(TICK_DIV - 1));
  assign slot_free = !evt_valid || evt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Stable level is judged on the history including this tick's sample.
  always_comb begin
    stable_nx = stable;
    post      = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      hist_nx[i] = hist[i];
      if (tick) begin
        hist_nx[i] = {hist[i][N-2:0], raw_in[i]};
        if ((&hist_nx[i]) && !stable[i]) begin
          stable_nx[i] = 1'b1;
          post[i]      = 1'b1;
        end else if (!(|hist_nx[i]) && stable[i]) begin
          stable_nx[i] = 1'b0;
          post[i]      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    int unsigned idx;
    gnt    = 1'b0;
    gnt_ch = '0;
    for (int unsigned k = 1; k <= CH; k++) begin
      idx = (32'(last) + k) % CH;
      if (!gnt && pend[CW'(idx)]) begin
        gnt    = 1'b1;
        gnt_ch = CW'(idx);
      end
    end
    gnt = gnt && slot_free;
  end

  // Clearing the granted bit before posting lets a same-cycle repost survive
  // without counting as an overwrite.
  always_comb begin
    pend_nx  = pend;
    ptype_nx = ptype;
    ovf_set  = 1'b0;
    if (gnt) begin
      pend_nx[gnt_ch] = 1'b0;
    end
    for (int unsigned i = 0; i < CH; i++) begin
      if (post[i]) begin
        if (pend_nx[i]) begin
          ovf_set = 1'b1;
        end
        pend_nx[i]  = 1'b1;
        ptype_nx[i] = stable_nx[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        hist[i] <= '0;
      end
      stable    <= '0;
      pend      <= '0;
      ptype     <= '0;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_press <= 1'b0;
      ovf       <= 1'b0;
      last      <= CW'(CH - 1);
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        hist[i] <= hist_nx[i];
      end
      stable <= stable_nx;
      pend   <= pend_nx;
      ptype  <= ptype_nx;
      ovf    <= ovf | ovf_set;
      if (slot_free) begin
        evt_valid <= gnt;
        if (gnt) begin
          evt_ch    <= gnt_ch;
          evt_press <= ptype[gnt_ch];
          last      <= gnt_ch;
        end
      end
    end
  end

endmodule

// File: tb/tb_debounce_event_ctrl.sv
// Bench for debounce_event_ctrl: directed scenarios plus random button activity,
// compared every cycle against a run-length / pending-set reference model.
module tb_debounce_event_ctrl;

  localparam int CH = 4;
  localparam int N  = 3;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] raw_in = '0;
  logic [CH-1:0] stable;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [1:0]    evt_ch;
  logic          evt_press;
  logic          ovf;

  int n_tests = 0;
  int n_fail  = 0;

  debounce_event_ctrl #(.CH(CH), .N(N), .TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .stable    (stable),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_press (evt_press),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: a channel's level flips once its latest run of equal
  // samples reaches N; events sit in a per-channel pending set.
  int            tcount;
  int            run_len [CH];
  logic [CH-1:0] run_val;
  logic [CH-1:0] m_stable, m_pend, m_ptype;
  logic          m_valid, m_press, m_ovf;
  int            m_ch, m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    tcount = 0;
    for (int i = 0; i < CH; i++) run_len[i] = N;
    run_val  = '0;
    m_stable = '0;
    m_pend   = '0;
    m_ptype  = '0;
    m_valid  = 1'b0;
    m_press  = 1'b0;
    m_ovf    = 1'b0;
    m_ch     = 0;
    m_last   = CH - 1;
  endfunction

  function automatic void model_step(input logic [CH-1:0] raw, input logic rdy);
    logic [CH-1:0] posts;
    int best, bestd, d;
    posts = '0;
    if ((tcount % TD) == TD - 1) begin
      for (int i = 0; i < CH; i++) begin
        if (raw[i] == run_val[i]) begin
          if (run_len[i] < N) run_len[i]++;
        end else begin
          run_val[i] = raw[i];
          run_len[i] = 1;
        end
        if (run_len[i] >= N && m_stable[i] != run_val[i]) begin
          m_stable[i] = run_val[i];
          posts[i]    = 1'b1;
        end
      end
    end
    tcount++;
    if (!m_valid || rdy) begin
      best  = -1;
      bestd = CH;
      for (int i = 0; i < CH; i++) begin
        d = (i - m_last - 1 + 2 * CH) % CH;
        if (m_pend[i] && d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
      if (best >= 0) begin
        m_valid      = 1'b1;
        m_ch         = best;
        m_press      = m_ptype[best];
        m_pend[best] = 1'b0;
        m_last       = best;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < CH; i++) begin
      if (posts[i]) begin
        if (m_pend[i]) m_ovf = 1'b1;
        m_pend[i]  = 1'b1;
        m_ptype[i] = m_stable[i];
      end
    end
  endfunction

  task automatic compare_all();
    check("stable", 32'(stable), 32'(m_stable));
    check("evt_valid", 32'(evt_valid), 32'(m_valid));
    if (m_valid) begin
      check("evt_ch", 32'(evt_ch), 32'(m_ch));
      check("evt_press", 32'(evt_press), 32'(m_press));
    end
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  // Called at a falling edge; drives inputs, advances one clock, checks at the next falling edge.
  task automatic step(input logic [CH-1:0] r, input logic rdy);
    raw_in    = r;
    evt_ready = rdy;
    @(posedge clk);
    model_step(r, rdy);
    @(negedge clk);
    compare_all();
  endtask

  logic [CH-1:0] rr;
  logic [5:0]    bounce_pat;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_stable", 32'(stable), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    // idle
    repeat (40) step(4'b0000, 1'b1);

    // clean press / release on ch2
    repeat (20) step(4'b0100, 1'b1);
    repeat (20) step(4'b0000, 1'b1);

    // bounce on ch1 across six ticks
    bounce_pat = 6'b101101;
    for (int t = 5; t >= 0; t--) begin
      repeat (TD) step({2'b00, bounce_pat[t], 1'b0}, 1'b1);
    end
    check("bounce_stable1", 32'(stable[1]), 32'd0);
    repeat (8) step(4'b0000, 1'b1);

    // simultaneous press ch0 + ch3, consumer stalled
    repeat (20) step(4'b1001, 1'b0);
    repeat (10) step(4'b1001, 1'b0);
    step(4'b1001, 1'b1);
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b1);
    step(4'b1001, 1'b0);
    repeat (20) step(4'b0000, 1'b1);

    // overflow on ch1 while ch0 press is stalled
    repeat (16) step(4'b0001, 1'b0);
    repeat (16) step(4'b0011, 1'b0);
    repeat (16) step(4'b0001, 1'b0);
    check("ovf_set", 32'(ovf), 32'd1);
    repeat (10) step(4'b0001, 1'b1);
    repeat (20) step(4'b0000, 1'b1);

    // random activity
    rr = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, (c % 500 < 100) ? 3 : 15) == 0) rr[i] = ~rr[i];
      end
      step(rr, ($urandom_range(0, 2) != 0));
    end

    // async reset between edges with events in flight
    repeat (20) step(4'b1111, 1'b0);
    repeat (20) step(4'b0000, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_valid", 32'(evt_valid), 32'd0);
    check("arst_stable", 32'(stable), 32'd0);
    check("arst_ch", 32'(evt_ch), 32'd0);
    check("arst_press", 32'(evt_press), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    raw_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) step(4'b0000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
